// File: rtl/lib_arbiter_pkg.sv
// Shared constants and types for the pixel-block arbiter/encoder path.
// Provides array geometry, the AER event width and type, and the encoder FSM state type.
package lib_arbiter_pkg;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned ROW_ADD = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_ADD = (COLS > 1) ? $clog2(COLS) : 1;

  localparam int unsigned TS_WIDTH_DEFAULT = 16;
  localparam int unsigned EVT_W = 1 + ROW_ADD + COL_ADD + TS_WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    ACK    = 2'd2,
    SETTLE = 2'd3
  } enc_state_t;

  // Event word at the default timestamp width; MSB first: polarity, row, column, timestamp.
  typedef struct packed {
    logic                        pol;
    logic [ROW_ADD-1:0]          x;
    logic [COL_ADD-1:0]          y;
    logic [TS_WIDTH_DEFAULT-1:0] ts;
  } aer_event_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with registered storage; the head is visible on rdata.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata, full, empty, count.
// A push into an empty FIFO shows up on rdata the following cycle.
module event_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];

  // Storage, pointers (natural wrap) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/aer_event_encoder.sv
// AER event encoder: tags each row/column grant with a timestamp and polarity,
// queues the event word and paces the row arbiter.
// Ports: clk_i, reset_ni (async active-low), enable_i; row_gnt_i/x_add_i and
// col_gnt_i/y_add_i/polarity_i from the arbiters; arb_en_o and row_ack_o back to
// the arbiter and pixel array; evt_valid_o/evt_ready_i/evt_data_o consumer side;
// fifo_full_o and stall_cnt_o status.
module aer_event_encoder
  import lib_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_WIDTH   = TS_WIDTH_DEFAULT
) (
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  input  logic                                 enable_i,
  input  logic [ROWS-1:0]                      row_gnt_i,
  input  logic [ROW_ADD-1:0]                   x_add_i,
  input  logic [COLS-1:0]                      col_gnt_i,
  input  logic [COL_ADD-1:0]                   y_add_i,
  input  logic                                 polarity_i,
  output logic                                 arb_en_o,
  output logic [ROWS-1:0]                      row_ack_o,
  output logic                                 evt_valid_o,
  input  logic                                 evt_ready_i,
  output logic [1+ROW_ADD+COL_ADD+TS_WIDTH-1:0] evt_data_o,
  output logic                                 fifo_full_o,
  output logic [7:0]                           stall_cnt_o
);

  localparam int unsigned EVT_WIDTH = 1 + ROW_ADD + COL_ADD + TS_WIDTH;
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

  enc_state_t           state;
  enc_state_t           state_next;
  logic [TS_WIDTH-1:0]  ts;
  logic [7:0]           stall_cnt;
  logic                 row_grant;
  logic                 col_grant;
  logic                 push;
  logic                 stall_inc;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [EVT_WIDTH-1:0] push_data;

  assign row_grant = |row_gnt_i;
  assign col_grant = |col_gnt_i;
  assign push_data = {polarity_i, x_add_i, y_add_i, ts};

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and arbiter handshake. arb_en_o/row_ack_o decode the state
  // directly so the arbiter sees them in the same cycle and reset clears them
  // asynchronously; they hold with the state while enable_i is low.
  always_comb begin
    state_next = state;
    arb_en_o   = 1'b0;
    row_ack_o  = '0;
    push       = 1'b0;
    stall_inc  = 1'b0;
    case (state)
      IDLE: begin
        arb_en_o = !row_grant;
        if (enable_i && row_grant) begin
          if (fifo_full) begin
            stall_inc = 1'b1;
          end else if (col_grant) begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        push = enable_i;
        if (enable_i) state_next = ACK;
      end
      ACK: begin
        row_ack_o = row_gnt_i;
        arb_en_o  = 1'b1;
        if (enable_i) state_next = SETTLE;
      end
      SETTLE: begin
        if (enable_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Free-running timestamp, frozen while disabled.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts <= '0;
    end else if (enable_i) begin
      ts <= ts + TS_WIDTH'(1);
    end
  end

  // Saturating count of cycles a grant waited on a full FIFO.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  event_fifo #(
    .WIDTH (EVT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (reset_ni),
    .push  (push),
    .wdata (push_data),
    .pop   (evt_ready_i),
    .rdata (evt_data_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign evt_valid_o = !fifo_empty;
  assign fifo_full_o = (fifo_count == CW'(FIFO_DEPTH));
  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Directed bench for aer_event_encoder (ROWS=COLS=4, TS_WIDTH=8, FIFO_DEPTH=4).
// Expected events are queued when a grant is issued; a monitor pops and compares
// whenever the consumer accepts the FIFO head.
module tb_aer_event_encoder;
  import lib_arbiter_pkg::*;

  localparam int unsigned TSW   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned EW    = 1 + ROW_ADD + COL_ADD + TSW;

  logic               clk_i = 1'b0;
  logic               reset_ni = 1'b0;
  logic               enable_i = 1'b1;
  logic [ROWS-1:0]    row_gnt_i = '0;
  logic [ROW_ADD-1:0] x_add_i = '0;
  logic [COLS-1:0]    col_gnt_i = '0;
  logic [COL_ADD-1:0] y_add_i = '0;
  logic               polarity_i = 1'b0;
  logic               arb_en_o;
  logic [ROWS-1:0]    row_ack_o;
  logic               evt_valid_o;
  logic               evt_ready_i = 1'b1;
  logic [EW-1:0]      evt_data_o;
  logic               fifo_full_o;
  logic [7:0]         stall_cnt_o;

  aer_event_encoder #(
    .FIFO_DEPTH (DEPTH),
    .TS_WIDTH   (TSW)
  ) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .enable_i    (enable_i),
    .row_gnt_i   (row_gnt_i),
    .x_add_i     (x_add_i),
    .col_gnt_i   (col_gnt_i),
    .y_add_i     (y_add_i),
    .polarity_i  (polarity_i),
    .arb_en_o    (arb_en_o),
    .row_ack_o   (row_ack_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_data_o  (evt_data_o),
    .fifo_full_o (fifo_full_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int now = 0;
  logic [EW-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the posedge that starts cycle k.
  task automatic at(input int k);
    repeat (k - now) @(posedge clk_i);
    #1;
    now = k;
  endtask

  task automatic drive(input logic [ROWS-1:0] rg, input logic [ROW_ADD-1:0] x,
                       input logic [COLS-1:0] cg, input logic [COL_ADD-1:0] y,
                       input logic p);
    row_gnt_i  = rg;
    x_add_i    = x;
    col_gnt_i  = cg;
    y_add_i    = y;
    polarity_i = p;
  endtask

  // Scoreboard monitor: compares every accepted head against the oldest expectation.
  always @(negedge clk_i) begin
    if (reset_ni && evt_valid_o && evt_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got 0x%0h, expected no event", evt_data_o);
      end else begin : pop_blk
        logic [EW-1:0] e;
        e = sb.pop_front();
        check("event_word", 32'(evt_data_o), 32'(e));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("in_reset_arb_en", 32'(arb_en_o), 32'd1);
    check("in_reset_valid", 32'(evt_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    now = 0;
    @(negedge clk_i);
    check("rst_arb_en", 32'(arb_en_o), 32'd1);
    check("rst_valid", 32'(evt_valid_o), 32'd0);
    check("rst_row_ack", 32'(row_ack_o), 32'd0);
    check("rst_full", 32'(fifo_full_o), 32'd0);
    check("rst_stall", 32'(stall_cnt_o), 32'd0);
    check("rst_data", 32'(evt_data_o), 32'd0);

    // Single event captured at timestamp 5.
    at(4);
    drive(4'b0100, 2'd2, 4'b0010, 2'd1, 1'b1);
    sb.push_back({1'b1, 2'd2, 2'd1, 8'd5});
    @(negedge clk_i);
    check("s1_idle_grant_arb_en", 32'(arb_en_o), 32'd0);
    at(5);
    @(negedge clk_i);
    check("s1_write_valid", 32'(evt_valid_o), 32'd0);
    check("s1_write_row_ack", 32'(row_ack_o), 32'd0);
    check("s1_write_arb_en", 32'(arb_en_o), 32'd0);
    at(6);
    @(negedge clk_i);
    check("s1_ack_row_ack", 32'(row_ack_o), 32'b0100);
    check("s1_ack_arb_en", 32'(arb_en_o), 32'd1);
    at(7);
    drive('0, '0, '0, '0, 1'b0);
    @(negedge clk_i);
    check("s1_settle_row_ack", 32'(row_ack_o), 32'd0);
    check("s1_settle_arb_en", 32'(arb_en_o), 32'd0);
    check("s1_popped_valid", 32'(evt_valid_o), 32'd0);

    // Held grant with a stalled consumer: four events fill the FIFO.
    at(8);
    evt_ready_i = 1'b0;
    drive(4'b0001, 2'd1, 4'b1000, 2'd3, 1'b0);
    sb.push_back({1'b0, 2'd1, 2'd3, 8'd9});
    sb.push_back({1'b0, 2'd1, 2'd3, 8'd13});
    sb.push_back({1'b0, 2'd1, 2'd3, 8'd17});
    sb.push_back({1'b0, 2'd1, 2'd3, 8'd21});
    at(21);
    @(negedge clk_i);
    check("s2_not_full_yet", 32'(fifo_full_o), 32'd0);
    at(22);
    @(negedge clk_i);
    check("s2_full", 32'(fifo_full_o), 32'd1);
    at(24);
    @(negedge clk_i);
    check("s2_stall_start", 32'(stall_cnt_o), 32'd0);
    check("s2_stall_arb_en", 32'(arb_en_o), 32'd0);
    at(27);
    @(negedge clk_i);
    check("s2_stall_cnt3", 32'(stall_cnt_o), 32'd3);
    check("s2_no_ack_stalled", 32'(row_ack_o), 32'd0);
    at(28);
    evt_ready_i = 1'b1;
    @(negedge clk_i);
    check("s2_full_before_pop", 32'(fifo_full_o), 32'd1);
    at(29);
    evt_ready_i = 1'b0;
    sb.push_back({1'b0, 2'd1, 2'd3, 8'd30});
    @(negedge clk_i);
    check("s2_after_pop_full", 32'(fifo_full_o), 32'd0);
    check("s2_stall_cnt5", 32'(stall_cnt_o), 32'd5);
    at(31);
    @(negedge clk_i);
    check("s2_ack_row_ack", 32'(row_ack_o), 32'b0001);
    at(32);
    drive('0, '0, '0, '0, 1'b0);
    at(33);
    evt_ready_i = 1'b1;
    at(40);
    @(negedge clk_i);
    check("s2_drained_valid", 32'(evt_valid_o), 32'd0);
    check("s2_sb_empty", 32'(sb.size()), 32'd0);

    // Timestamp wrap: 8'hFF then 8'h03.
    at(254);
    drive(4'b1000, 2'd3, 4'b0001, 2'd0, 1'b1);
    sb.push_back({1'b1, 2'd3, 2'd0, 8'hFF});
    sb.push_back({1'b1, 2'd3, 2'd0, 8'h03});
    at(261);
    drive('0, '0, '0, '0, 1'b0);
    at(266);
    @(negedge clk_i);
    check("s3_valid", 32'(evt_valid_o), 32'd0);
    check("s3_sb_empty", 32'(sb.size()), 32'd0);

    // Enable dropped for three cycles while in ACK.
    at(300);
    drive(4'b0010, 2'd0, 4'b0100, 2'd2, 1'b0);
    sb.push_back({1'b0, 2'd0, 2'd2, 8'd45});
    at(302);
    enable_i = 1'b0;
    for (int k = 302; k <= 305; k++) begin
      at(k);
      if (k == 305) enable_i = 1'b1;
      @(negedge clk_i);
      check("s4_held_row_ack", 32'(row_ack_o), 32'b0010);
      check("s4_held_arb_en", 32'(arb_en_o), 32'd1);
    end
    at(306);
    drive('0, '0, '0, '0, 1'b0);
    @(negedge clk_i);
    check("s4_settle_row_ack", 32'(row_ack_o), 32'd0);
    check("s4_settle_arb_en", 32'(arb_en_o), 32'd0);
    at(307);
    @(negedge clk_i);
    check("s4_idle_arb_en", 32'(arb_en_o), 32'd1);
    at(310);
    drive(4'b0100, 2'd2, 4'b0010, 2'd1, 1'b1);
    sb.push_back({1'b1, 2'd2, 2'd1, 8'd52});
    at(313);
    drive('0, '0, '0, '0, 1'b0);
    at(316);
    @(negedge clk_i);
    check("s4_valid", 32'(evt_valid_o), 32'd0);
    check("s4_sb_empty", 32'(sb.size()), 32'd0);

    // Reset in WRITE with two entries queued.
    at(320);
    evt_ready_i = 1'b0;
    drive(4'b0001, 2'd1, 4'b0001, 2'd0, 1'b1);
    at(329);
    @(negedge clk_i);
    check("s5_queued_valid", 32'(evt_valid_o), 32'd1);
    check("s5_stall_before", 32'(stall_cnt_o), 32'd5);
    #1;
    reset_ni = 1'b0;
    drive('0, '0, '0, '0, 1'b0);
    #1;
    check("s5_async_valid", 32'(evt_valid_o), 32'd0);
    check("s5_async_row_ack", 32'(row_ack_o), 32'd0);
    check("s5_async_stall", 32'(stall_cnt_o), 32'd0);
    check("s5_async_full", 32'(fifo_full_o), 32'd0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    now = 0;
    @(negedge clk_i);
    check("s5_release_arb_en", 32'(arb_en_o), 32'd1);
    check("s5_release_valid", 32'(evt_valid_o), 32'd0);

    // Reset during ACK clears row_ack_o without a clock edge.
    at(2);
    drive(4'b1000, 2'd3, 4'b1000, 2'd3, 1'b0);
    at(4);
    @(negedge clk_i);
    check("s6_ack_row_ack", 32'(row_ack_o), 32'b1000);
    check("s6_ack_valid", 32'(evt_valid_o), 32'd1);
    #1;
    reset_ni = 1'b0;
    #1;
    check("s6_async_row_ack", 32'(row_ack_o), 32'd0);
    check("s6_async_valid", 32'(evt_valid_o), 32'd0);
    drive('0, '0, '0, '0, 1'b0);
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    evt_ready_i = 1'b1;
    now = 0;
    at(5);
    @(negedge clk_i);
    check("s6_final_valid", 32'(evt_valid_o), 32'd0);
    check("s6_final_arb_en", 32'(arb_en_o), 32'd1);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
